// File: rtl/ppl_fetch_pkg.sv
`default_nettype none
// ============================================================================
// ppl_fetch_pkg : shared FSM encoding, queue entry type and PC constants
// Revision 1.0
// ============================================================================
package ppl_fetch_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_DROP = 2'd2
  } fetch_state_e;

  localparam logic [31:0] PC_STEP      = 32'd4;
  // The PC register resets here so that the first sequential fetch lands on 0.
  localparam logic [31:0] PC_RESET_VAL = 32'hFFFF_FFFC;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ppl_fetch_if.sv
`default_nettype none
// ============================================================================
// ppl_fetch_if : PC register, instruction memory, redirect and ID-side signals
// Revision 1.0
// ============================================================================
interface ppl_fetch_if;

  logic [31:0] pc_cur;
  logic [31:0] pc_next;
  logic        pc_continue;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        id_ready;
  logic        if_valid;
  logic [31:0] if_instr;
  logic [31:0] if_pc;

  modport master (
    input  pc_cur, imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready,
    output pc_next, pc_continue, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

  modport slave (
    output pc_cur, imem_ack, imem_rdata, redirect_valid, redirect_pc, id_ready,
    input  pc_next, pc_continue, imem_req, imem_addr, if_valid, if_instr, if_pc
  );

endinterface
`default_nettype wire

// File: rtl/ppl_fetch_fifo.sv
`default_nettype none
// ============================================================================
// ppl_fetch_fifo : QDEPTH-entry {pc,instr} queue with push/pop/flush
// Revision 1.0
// ============================================================================
module ppl_fetch_fifo
  import ppl_fetch_pkg::*;
#(
  parameter int QDEPTH = 2
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      flush,
  input  logic                      push,
  input  fetch_entry_t              push_data,
  input  logic                      pop,
  output fetch_entry_t              head,
  output logic [$clog2(QDEPTH):0]   count,
  output logic                      full,
  output logic                      empty
);

  localparam int AW = $clog2(QDEPTH);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   count_q, count_d;
  fetch_entry_t  mem_q [QDEPTH];
  fetch_entry_t  mem_d [QDEPTH];
  logic          do_push;
  logic          do_pop;

  assign full    = (count_q == (AW+1)'(QDEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign head    = mem_q[rd_ptr_q];
  assign do_pop  = pop & ~empty;
  // A full queue still accepts a push when the head leaves in the same cycle.
  assign do_push = push & (~full | do_pop);

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (do_push) begin
        mem_d[wr_ptr_q] = push_data;
        wr_ptr_d        = wr_ptr_q + 1'b1;
      end
      if (do_pop) begin
        rd_ptr_d = rd_ptr_q + 1'b1;
      end
      count_d = count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

endmodule
`default_nettype wire

// File: rtl/ppl_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// ppl_fetch_ctrl : IF-stage fetch controller (PC advance, imem req/ack, queue)
// Optional perf counters enabled by defining PPL_FETCH_PERF_EN.  Revision 1.0
// ============================================================================
module ppl_fetch_ctrl #(
  parameter int          QDEPTH  = 2,
  parameter logic [31:0] PC_STEP = ppl_fetch_pkg::PC_STEP
) (
  input  logic        clk,
  input  logic        reset,
  ppl_fetch_if.master bus
`ifdef PPL_FETCH_PERF_EN
  ,
  output logic [31:0] perf_fetch,
  output logic [31:0] perf_flush
`endif
);

  import ppl_fetch_pkg::*;

  fetch_state_e             state_q, state_d;
  logic [31:0]              addr_q, addr_d;
  logic [31:0]              pc_next;
  logic                     pc_continue;
  logic                     fifo_push;
  logic                     fifo_pop;
  logic                     fifo_flush;
  logic                     fifo_full;
  logic                     fifo_empty;
  logic [$clog2(QDEPTH):0]  fifo_count;
  fetch_entry_t             push_data;
  fetch_entry_t             head;
  logic                     in_flight;
  logic                     can_issue;

  assign in_flight = (state_q == ST_REQ);
  assign can_issue = ~fifo_full && ((int'(fifo_count) + int'(in_flight)) < QDEPTH);
  assign push_data = '{pc: addr_q, instr: bus.imem_rdata};
  assign fifo_pop  = ~fifo_empty & bus.id_ready;

  // Redirect outranks issue and push; reset suppresses every decision.
  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    pc_next     = '0;
    pc_continue = 1'b0;
    fifo_push   = 1'b0;
    fifo_flush  = 1'b0;
    if (!reset) begin
      if (bus.redirect_valid) begin
        fifo_flush  = 1'b1;
        pc_next     = bus.redirect_pc - PC_STEP;
        pc_continue = 1'b1;
        case (state_q)
          ST_REQ:  state_d = bus.imem_ack ? ST_IDLE : ST_DROP;
          ST_DROP: state_d = bus.imem_ack ? ST_IDLE : ST_DROP;
          default: state_d = ST_IDLE;
        endcase
      end else begin
        case (state_q)
          ST_IDLE: begin
            if (can_issue) begin
              addr_d      = bus.pc_cur + PC_STEP;
              pc_next     = bus.pc_cur + PC_STEP;
              pc_continue = 1'b1;
              state_d     = ST_REQ;
            end
          end
          ST_REQ: begin
            if (bus.imem_ack) begin
              fifo_push = 1'b1;
              state_d   = ST_IDLE;
            end
          end
          ST_DROP: begin
            if (bus.imem_ack) begin
              state_d = ST_IDLE;
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  ppl_fetch_fifo #(
    .QDEPTH (QDEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .flush     (fifo_flush),
    .push      (fifo_push),
    .push_data (push_data),
    .pop       (fifo_pop),
    .head      (head),
    .count     (fifo_count),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign bus.pc_next     = pc_next;
  assign bus.pc_continue = pc_continue;
  assign bus.imem_req    = (state_q != ST_IDLE);
  assign bus.imem_addr   = addr_q;
  assign bus.if_valid    = ~fifo_empty;
  assign bus.if_instr    = head.instr;
  assign bus.if_pc       = head.pc;

`ifdef PPL_FETCH_PERF_EN
  logic [31:0] perf_fetch_q, perf_fetch_d;
  logic [31:0] perf_flush_q, perf_flush_d;

  always_comb begin
    perf_fetch_d = fifo_push  ? sat_inc(perf_fetch_q) : perf_fetch_q;
    perf_flush_d = fifo_flush ? sat_inc(perf_flush_q) : perf_flush_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetch_q <= '0;
      perf_flush_q <= '0;
    end else begin
      perf_fetch_q <= perf_fetch_d;
      perf_flush_q <= perf_flush_d;
    end
  end

  assign perf_fetch = perf_fetch_q;
  assign perf_flush = perf_flush_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ppl_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// tb_ppl_fetch_ctrl : directed bench with a PC register model and imem stub
// Revision 1.0
// ============================================================================
module tb_ppl_fetch_ctrl;
  import ppl_fetch_pkg::*;

  logic clk = 1'b0;
  logic reset;
  int   n_vec = 0;
  int   n_bad = 0;

  always #5 clk = ~clk;

  ppl_fetch_if bus();

`ifdef PPL_FETCH_PERF_EN
  logic [31:0] perf_fetch;
  logic [31:0] perf_flush;
`endif

  ppl_fetch_ctrl #(
    .QDEPTH  (2),
    .PC_STEP (32'd4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
`ifdef PPL_FETCH_PERF_EN
    ,
    .perf_fetch (perf_fetch),
    .perf_flush (perf_flush)
`endif
  );

  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return a ^ 32'hA5A5_0000;
  endfunction

  // PC register and memory stub: data is a fixed function of the address.
  always_ff @(posedge clk) begin
    if (reset)                bus.pc_cur <= PC_RESET_VAL;
    else if (bus.pc_continue) bus.pc_cur <= bus.pc_next;
  end
  assign bus.imem_rdata = instr_of(bus.imem_addr);

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #50000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] a;
    reset              = 1'b1;
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b0;
    bus.redirect_pc    = '0;
    bus.id_ready       = 1'b1;
    tick(); tick();
    #1;
    chk("rst_req",    32'(bus.imem_req),    32'd0);
    chk("rst_valid",  32'(bus.if_valid),    32'd0);
    chk("rst_cont",   32'(bus.pc_continue), 32'd0);
    chk("rst_pcnext", bus.pc_next,          32'd0);

    // Sequential fetch with immediate ack and a consuming ID stage
    reset = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      a = 32'(k) * 32'd4;
      chk("t1_cont",   32'(bus.pc_continue), 32'd1);
      chk("t1_pcnext", bus.pc_next, a);
      if (k > 0) begin
        chk("t1_valid", 32'(bus.if_valid), 32'd1);
        chk("t1_ifpc",  bus.if_pc, a - 32'd4);
        chk("t1_instr", bus.if_instr, instr_of(a - 32'd4));
      end
      tick();
      bus.imem_ack = 1'b1;
      #1;
      chk("t1_req",  32'(bus.imem_req), 32'd1);
      chk("t1_addr", bus.imem_addr, a);
      chk("t1_hold", 32'(bus.pc_continue), 32'd0);
      tick();
      bus.imem_ack = 1'b0;
      #1;
    end

    // Back-pressure: queue fills after two pushes, issue stalls
    reset = 1'b1;
    tick(); tick();
    reset        = 1'b0;
    bus.id_ready = 1'b0;
    bus.imem_ack = 1'b1;
    #1;
    chk("t2_pcnext0", bus.pc_next, 32'd0);
    tick();
    chk("t2_addr0", bus.imem_addr, 32'd0);
    tick();
    chk("t2_pcnext4", bus.pc_next, 32'd4);
    chk("t2_ifpc0",   bus.if_pc, 32'd0);
    tick();
    chk("t2_addr4", bus.imem_addr, 32'd4);
    tick();
    chk("t2_full_req",  32'(bus.imem_req), 32'd0);
    chk("t2_full_cont", 32'(bus.pc_continue), 32'd0);
    chk("t2_full_val",  32'(bus.if_valid), 32'd1);
    tick();
    chk("t2_full_req2", 32'(bus.imem_req), 32'd0);
    bus.id_ready = 1'b1;
    #1;
    chk("t2_pop_cont", 32'(bus.pc_continue), 32'd0);
    tick();
    bus.id_ready = 1'b0;
    #1;
    chk("t2_res_cont",   32'(bus.pc_continue), 32'd1);
    chk("t2_res_pcnext", bus.pc_next, 32'd8);
    chk("t2_res_ifpc",   bus.if_pc, 32'd4);
    tick();
    chk("t2_res_addr", bus.imem_addr, 32'd8);

    // Redirect while idle with a full queue
    tick();
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h100;
    #1;
    chk("t3_cont",   32'(bus.pc_continue), 32'd1);
    chk("t3_pcnext", bus.pc_next, 32'hFC);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t3_flushed", 32'(bus.if_valid), 32'd0);
    chk("t3_pcnext2", bus.pc_next, 32'h100);
    tick();
    chk("t3_addr", bus.imem_addr, 32'h100);

    // Redirect during an outstanding request; late ack must be dropped
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h200;
    #1;
    chk("t4_pcnext", bus.pc_next, 32'h1FC);
    tick();
    bus.redirect_valid = 1'b0;
    #1;
    chk("t4_drop_req",  32'(bus.imem_req), 32'd1);
    chk("t4_drop_cont", 32'(bus.pc_continue), 32'd0);
    tick();
    chk("t4_drop_val", 32'(bus.if_valid), 32'd0);
    tick();
    bus.imem_ack = 1'b1;
    #1;
    chk("t4_drop_req2", 32'(bus.imem_req), 32'd1);
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk("t4_no_push", 32'(bus.if_valid), 32'd0);
    chk("t4_pcnext2", bus.pc_next, 32'h200);
    tick();
    chk("t4_addr", bus.imem_addr, 32'h200);
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk("t4_ifpc",  bus.if_pc, 32'h200);
    chk("t4_instr", bus.if_instr, instr_of(32'h200));

    // Redirect coincident with ack that would fill the queue
    tick();
    chk("t5_addr", bus.imem_addr, 32'h204);
    bus.imem_ack       = 1'b1;
    bus.redirect_valid = 1'b1;
    bus.redirect_pc    = 32'h300;
    #1;
    chk("t5_pcnext", bus.pc_next, 32'h2FC);
    tick();
    bus.imem_ack       = 1'b0;
    bus.redirect_valid = 1'b0;
    #1;
    chk("t5_empty",   32'(bus.if_valid), 32'd0);
    chk("t5_idle",    32'(bus.imem_req), 32'd0);
    chk("t5_pcnext2", bus.pc_next, 32'h300);
    tick();
    chk("t5_addr2", bus.imem_addr, 32'h300);

    // Reset in the middle of a request with data queued
    bus.imem_ack = 1'b1;
    tick();
    bus.imem_ack = 1'b0;
    #1;
    chk("t6_ifpc", bus.if_pc, 32'h300);
    tick();
    chk("t6_req_pre", 32'(bus.imem_req), 32'd1);
    reset = 1'b1;
    tick();
    chk("t6_req",    32'(bus.imem_req), 32'd0);
    chk("t6_valid",  32'(bus.if_valid), 32'd0);
    chk("t6_cont",   32'(bus.pc_continue), 32'd0);
    chk("t6_pcnext", bus.pc_next, 32'd0);
    reset = 1'b0;
    #1;
    chk("t6_cont2",   32'(bus.pc_continue), 32'd1);
    chk("t6_pcnext2", bus.pc_next, 32'd0);
    tick();
    chk("t6_addr", bus.imem_addr, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
